clksplt_tree: RTL and testbench
===============================

Name: clksplt_tree

Overview:
- Parametrised successor to the two-way RSFQ clock splitter behavioural cell.
- Models an N-way toggle-encoded clock distribution node in a synchronous sampling domain.
- Each edge on `a` is one pulse. It is forwarded to every enabled output channel after a fixed latency, with optional per-channel pulse division.
- Adds what the fixed splitter lacks: startup settling window, minimum-spacing (hold) check with drop-and-flag, per-channel enable and divide.

Parameters:
- NUM_OUT, 2, number of output channels (>=2)
- LATENCY, 3, clk cycles from accepted input edge to output toggle (>=1)
- MIN_SPACING, 4, minimum clk cycles between accepted input edges (>=1)
- BEGIN_CYCLES, 8, clk cycles after reset release before input edges are accepted
- DIV_W, 4, width of each channel's divide selector

Ports:
- clk  input  1  sampling clock, all logic on rising edge
- rst_n  input  1  synchronous active-low reset
- a  input  1  toggle-encoded pulse input; both rising and falling transitions are events
- en_mask  input  NUM_OUT  per-channel enable, bit i gates q[i]
- div_sel  input  NUM_OUT*DIV_W  channel i divide ratio = div_sel[i*DIV_W +: DIV_W] + 1
- q  output  NUM_OUT  toggle-encoded pulse outputs
- ready  output  1  high once startup window has elapsed
- viol  output  1  one-cycle pulse on a rejected (too-close) input event

Behaviour:
- Reset (rst_n low at a clk edge):
  - q=0, ready=0, viol=0.
  - Delay pipeline, divider counters and startup counter cleared.
  - Spacing tracker marked "no prior event".
  - a_prev loaded with current a, so there is no spurious event on release.
- Event detection: event at edge k when a != a_prev. a_prev <= a every cycle, including when not ready.
- Startup:
  - Counter increments each cycle after release.
  - ready goes to 1 at the BEGIN_CYCLES-th edge after release and stays 1 until reset.
  - Events while ready=0 are ignored: no viol, not counted, spacing tracker unchanged.
- Spacing check: with ready=1, an event is accepted if there is no prior accepted event, or if cycles since the last accepted event >= MIN_SPACING.
- Rejected event:
  - viol=1 for exactly the following cycle.
  - Event not forwarded.
  - Spacing is still measured from the last accepted event.
- Gap counter saturates, so there is no wrap false-violation.
- Accepted event enters a LATENCY-deep 1-bit shift pipeline. Multiple events may be in flight.
- An event accepted at edge k is visible on q at edge k+LATENCY.
- Pipeline output, per channel i:
  - en_mask[i]=0: no toggle, counter cnt_i held.
  - en_mask[i]=1 and cnt_i >= sel_i: q[i] toggles, cnt_i <= 0.
  - Otherwise: cnt_i <= cnt_i+1.
  - en_mask and div_sel are sampled at the pipeline-output cycle, not at input acceptance.
  - div_sel lowered mid-count below cnt_i: the next event toggles and clears.
- Reset mid-flight: in-flight events are discarded; no toggle appears after release.
- Simultaneous rst_n low and event: reset wins.

Optional Feature:
- Macro CLKSPLT_VIOL_CNT_EN.
- When defined:
  - Adds output port viol_count, 8 bits.
  - Saturating count of rejected events; holds at 255.
  - Cleared only by reset.
  - Events ignored before ready are not counted.
- When undefined: port and counter absent; all other behaviour identical.

Test Plan:
- All scenarios use the defaults (NUM_OUT=2, LATENCY=3, MIN_SPACING=4, BEGIN_CYCLES=8).
1. Startup window: release reset, toggle a at edge 3 after release.
   - ready=0 through edge 7, ready=1 at edge 8.
   - q stays 2'b00, viol never asserts.
2. Basic latency: ready=1, en_mask=2'b11, div_sel=0, toggle a so event is at edge k.
   - q toggles to 2'b11 at edge k+3.
   - Second toggle at k+4 returns q to 2'b00 at k+7.
3. Spacing violation: events at edges k and k+2.
   - viol=1 for the cycle after k+2.
   - q toggles once only.
   - viol_count=1 with CLKSPLT_VIOL_CNT_EN.
   - Next event at k+4 is accepted.
4. Divide: div_sel ch0=0, ch1=2; six events spaced 5 cycles apart.
   - q[0] toggles 6 times.
   - q[1] toggles on events 3 and 6 only.
5. Enable mask: en_mask=2'b01, four accepted events.
   - q[1] constant 0, q[0] toggles 4 times.
   - Set en_mask=2'b11: q[1] toggles on the next event.
6. Reset mid-flight and saturation:
   - Event accepted at k, rst_n low at k+1: q=0 after reset, no toggle after release.
   - With the macro, 300 violations give viol_count=255.

Source files
------------

// File: rtl/clksplt_tree.sv
// clksplt_tree: N-way toggle-encoded clock splitter with startup window, spacing check, per-channel enable/divide.
// Latency: an accepted edge on a toggles q after LATENCY clk cycles; viol pulses one cycle after a rejected edge.
// Backpressure: none, too-close edges are dropped and flagged; CLKSPLT_VIOL_CNT_EN adds a saturating viol_count.
module clksplt_tree #(
  parameter int NUM_OUT      = 2,
  parameter int LATENCY      = 3,
  parameter int MIN_SPACING  = 4,
  parameter int BEGIN_CYCLES = 8,
  parameter int DIV_W        = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     a,
  input  logic [NUM_OUT-1:0]       en_mask,
  input  logic [NUM_OUT*DIV_W-1:0] div_sel,
  output logic [NUM_OUT-1:0]       q,
  output logic                     ready,
  output logic                     viol
`ifdef CLKSPLT_VIOL_CNT_EN
  ,
  output logic [7:0]               viol_count
`endif
);

  localparam int BC    = (BEGIN_CYCLES < 1) ? 1 : BEGIN_CYCLES;
  localparam int SU_W  = (BC < 2) ? 1 : $clog2(BC);
  localparam int GAP_W = (MIN_SPACING < 2) ? 1 : $clog2(MIN_SPACING + 1);
  localparam logic [SU_W-1:0]  SU_LAST = SU_W'(BC - 1);
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(MIN_SPACING);

  logic                 r_a_prev;
  logic [SU_W-1:0]      r_su;
  logic                 r_ready;
  logic                 r_have;
  logic [GAP_W-1:0]     r_gap;
  logic [LATENCY-1:0]   r_pipe;
  logic [NUM_OUT-1:0]   r_q;
  logic [DIV_W-1:0]     r_div [NUM_OUT];
  logic                 r_viol;

  logic w_evt;
  logic w_acc;
  logic w_rej;
  logic w_fire;

  assign w_evt  = a ^ r_a_prev;
  assign w_acc  = w_evt & r_ready & (~r_have | (r_gap >= GAP_MAX));
  assign w_rej  = w_evt & r_ready & ~w_acc;
  assign w_fire = r_pipe[LATENCY-1];

  always_ff @(posedge clk) begin
    // a_prev tracks a even in reset so release never creates a phantom edge
    r_a_prev <= a;
    if (!rst_n) begin
      r_su    <= '0;
      r_ready <= 1'b0;
      r_have  <= 1'b0;
      r_gap   <= '0;
      r_pipe  <= '0;
      r_q     <= '0;
      r_viol  <= 1'b0;
      for (int i = 0; i < NUM_OUT; i++) r_div[i] <= '0;
    end else begin
      if (!r_ready) begin
        if (r_su == SU_LAST) r_ready <= 1'b1;
        else                 r_su    <= r_su + 1'b1;
      end

      r_viol <= w_rej;

      if (w_acc) begin
        r_have <= 1'b1;
        r_gap  <= GAP_W'(1);
      end else if (r_gap < GAP_MAX) begin
        r_gap <= r_gap + 1'b1;
      end

      r_pipe[0] <= w_acc;
      for (int i = 1; i < LATENCY; i++) r_pipe[i] <= r_pipe[i-1];

      // divide settings are taken at the output cycle, so a lowered ratio fires at once
      for (int i = 0; i < NUM_OUT; i++) begin
        if (w_fire && en_mask[i]) begin
          if (r_div[i] >= div_sel[i*DIV_W +: DIV_W]) begin
            r_q[i]   <= ~r_q[i];
            r_div[i] <= '0;
          end else begin
            r_div[i] <= r_div[i] + 1'b1;
          end
        end
      end
    end
  end

`ifdef CLKSPLT_VIOL_CNT_EN
  logic [7:0] r_vcnt;

  always_ff @(posedge clk) begin
    if (!rst_n)                       r_vcnt <= '0;
    else if (w_rej && r_vcnt != 8'hFF) r_vcnt <= r_vcnt + 1'b1;
  end

  assign viol_count = r_vcnt;
`endif

  assign q     = r_q;
  assign ready = r_ready;
  assign viol  = r_viol;

endmodule

// File: tb/tb_clksplt_tree.sv
// Bench for clksplt_tree: scenario tasks plus a randomized run, checked against a timestamp-based model.
module tb_clksplt_tree;
  localparam int NUM_OUT = 2, LATENCY = 3, MIN_SPACING = 4, BEGIN_CYCLES = 8, DIV_W = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a;
  logic [1:0] en_mask;
  logic [7:0] div_sel;
  logic [1:0] q;
  logic       ready;
  logic       viol;
`ifdef CLKSPLT_VIOL_CNT_EN
  logic [7:0] viol_count;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  clksplt_tree #(
    .NUM_OUT(NUM_OUT), .LATENCY(LATENCY), .MIN_SPACING(MIN_SPACING),
    .BEGIN_CYCLES(BEGIN_CYCLES), .DIV_W(DIV_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .en_mask(en_mask), .div_sel(div_sel),
    .q(q), .ready(ready), .viol(viol)
`ifdef CLKSPLT_VIOL_CNT_EN
    , .viol_count(viol_count)
`endif
  );

  // Reference model: absolute cycle stamps, a queue of output due times, per-channel tallies
  int         cyc = 0;
  int         m_since;
  int         m_last;
  int         m_vcnt;
  int         m_cnt [2];
  int         m_due [$];
  bit         m_ready;
  bit         m_viol;
  logic       m_aprev;
  logic [1:0] m_q;

  task automatic apply_out();
    for (int i = 0; i < NUM_OUT; i++) begin
      if (en_mask[i]) begin
        if (m_cnt[i] >= int'(div_sel[i*DIV_W +: DIV_W])) begin
          m_q[i]   = ~m_q[i];
          m_cnt[i] = 0;
        end else begin
          m_cnt[i] = m_cnt[i] + 1;
        end
      end
    end
  endtask

  task automatic tick();
    bit evt;
    bit rdy_before;
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      m_since = 0; m_ready = 0; m_aprev = a; m_viol = 0; m_q = 2'b00;
      m_cnt[0] = 0; m_cnt[1] = 0; m_vcnt = 0; m_last = -1;
      m_due.delete();
    end else begin
      evt        = (a !== m_aprev);
      rdy_before = m_ready;
      m_aprev    = a;
      m_viol     = 0;
      while (m_due.size() > 0 && m_due[0] == cyc) begin
        void'(m_due.pop_front());
        apply_out();
      end
      if (evt && rdy_before) begin
        if (m_last < 0 || cyc - m_last >= MIN_SPACING) begin
          m_last = cyc;
          m_due.push_back(cyc + LATENCY);
        end else begin
          m_viol = 1;
          if (m_vcnt < 255) m_vcnt++;
        end
      end
      m_since++;
      m_ready = (m_since >= BEGIN_CYCLES);
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; a = 1'b0; en_mask = 2'b11; div_sel = 8'h00;
    tick(); tick();
    n_chk++; if (q !== 2'b00) begin n_fail++; $display("FAIL reset_q got=%b exp=00", q); end
    n_chk++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", ready); end
    n_chk++; if (viol !== 1'b0) begin n_fail++; $display("FAIL reset_viol got=%b exp=0", viol); end
`ifdef CLKSPLT_VIOL_CNT_EN
    n_chk++; if (viol_count !== 8'd0) begin n_fail++; $display("FAIL reset_vcnt got=%0d exp=0", viol_count); end
`endif
  endtask

  task automatic test_startup();
    rst_n = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      if (e == 3) a = ~a;
      tick();
      n_chk++;
      if (ready !== (e >= 8) || ready !== m_ready)
        begin n_fail++; $display("FAIL startup_ready edge=%0d got=%b exp=%b", e, ready, e >= 8); end
      n_chk++;
      if (q !== 2'b00 || viol !== 1'b0)
        begin n_fail++; $display("FAIL startup_quiet edge=%0d q=%b viol=%b exp q=00 viol=0", e, q, viol); end
    end
  endtask

  task automatic test_latency();
    en_mask = 2'b11; div_sel = 8'h00;
    idle(2);
    for (int j = 0; j <= 8; j++) begin
      if (j == 0 || j == 4) a = ~a;
      tick();
      n_chk++;
      if (q !== ((j >= 3 && j < 7) ? 2'b11 : 2'b00) || q !== m_q)
        begin n_fail++; $display("FAIL latency_q k+%0d got=%b exp=%b", j, q, (j >= 3 && j < 7) ? 2'b11 : 2'b00); end
    end
  endtask

  task automatic test_spacing();
    logic [1:0] prevq;
    idle(6);
    for (int j = 0; j <= 9; j++) begin
      if (j == 0 || j == 2 || j == 4) a = ~a;
      prevq = q;
      tick();
      n_chk++;
      if (viol !== (j == 2) || viol !== m_viol)
        begin n_fail++; $display("FAIL spacing_viol k+%0d got=%b exp=%b", j, viol, j == 2); end
      n_chk++;
      if ((q !== prevq) !== (j == 3 || j == 7) || q !== m_q)
        begin n_fail++; $display("FAIL spacing_q k+%0d got=%b prev=%b model=%b", j, q, prevq, m_q); end
    end
`ifdef CLKSPLT_VIOL_CNT_EN
    n_chk++; if (viol_count !== 8'd1) begin n_fail++; $display("FAIL spacing_vcnt got=%0d exp=1", viol_count); end
`endif
  endtask

  task automatic test_divide();
    logic [1:0] prevq;
    en_mask = 2'b11; div_sel = {4'd2, 4'd0};
    idle(6);
    for (int n = 1; n <= 6; n++) begin
      for (int t = 0; t < 5; t++) begin
        if (t == 0) a = ~a;
        prevq = q;
        tick();
        n_chk++;
        if ((q[0] !== prevq[0]) !== (t == 3) || (q[1] !== prevq[1]) !== (t == 3 && (n == 3 || n == 6)) || q !== m_q)
          begin n_fail++; $display("FAIL divide ev=%0d t=%0d q=%b prev=%b model=%b", n, t, q, prevq, m_q); end
      end
    end
  endtask

  task automatic test_enable();
    logic [1:0] prevq;
    en_mask = 2'b01; div_sel = 8'h00;
    idle(6);
    for (int n = 1; n <= 5; n++) begin
      if (n == 5) en_mask = 2'b11;
      for (int t = 0; t < 5; t++) begin
        if (t == 0) a = ~a;
        prevq = q;
        tick();
        n_chk++;
        if ((q[0] !== prevq[0]) !== (t == 3) || (q[1] !== prevq[1]) !== (t == 3 && n == 5) || q !== m_q)
          begin n_fail++; $display("FAIL enable ev=%0d t=%0d q=%b prev=%b model=%b", n, t, q, prevq, m_q); end
      end
    end
  endtask

  task automatic test_reset_midflight();
    en_mask = 2'b11; div_sel = 8'h00;
    idle(6);
    a = ~a;
    tick();
    rst_n = 1'b0;
    tick();
    n_chk++;
    if (q !== 2'b00 || ready !== 1'b0 || viol !== 1'b0)
      begin n_fail++; $display("FAIL midflight_reset q=%b ready=%b viol=%b exp 00/0/0", q, ready, viol); end
    rst_n = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      tick();
      n_chk++;
      if (q !== 2'b00 || q !== m_q)
        begin n_fail++; $display("FAIL midflight_q edge=%0d got=%b exp=00", j, q); end
    end
  endtask

  task automatic test_saturation();
    int nviol = 0;
    idle(2);
    for (int j = 0; j < 420; j++) begin
      a = ~a;
      tick();
      if (viol === 1'b1) nviol++;
      n_chk++;
      if (viol !== m_viol || q !== m_q)
        begin n_fail++; $display("FAIL sat_model j=%0d viol=%b q=%b exp viol=%b q=%b", j, viol, q, m_viol, m_q); end
    end
    n_chk++; if (nviol !== 315) begin n_fail++; $display("FAIL sat_nviol got=%0d exp=315", nviol); end
`ifdef CLKSPLT_VIOL_CNT_EN
    n_chk++; if (viol_count !== 8'd255) begin n_fail++; $display("FAIL sat_vcnt got=%0d exp=255", viol_count); end
`endif
  endtask

  task automatic test_random();
    for (int j = 0; j < 800; j++) begin
      if ($urandom_range(2) == 0) a = ~a;
      if ($urandom_range(49) == 0) en_mask = 2'($urandom_range(3));
      if ($urandom_range(39) == 0) div_sel = {2'b00, 2'($urandom_range(3)), 2'b00, 2'($urandom_range(3))};
      rst_n = ($urandom_range(199) != 0);
      tick();
      n_chk++;
      if (q !== m_q || viol !== m_viol || ready !== m_ready)
        begin n_fail++; $display("FAIL random cyc=%0d q=%b viol=%b ready=%b exp q=%b viol=%b ready=%b",
                                 cyc, q, viol, ready, m_q, m_viol, m_ready); end
`ifdef CLKSPLT_VIOL_CNT_EN
      n_chk++;
      if (viol_count !== 8'(m_vcnt))
        begin n_fail++; $display("FAIL random_vcnt cyc=%0d got=%0d exp=%0d", cyc, viol_count, m_vcnt); end
`endif
    end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_startup();
    test_latency();
    test_spacing();
    test_divide();
    test_enable();
    test_reset_midflight();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
